axil_adder_array: RTL
=====================

Name: axil_adder_array

Overview:
- AXI4-Lite slave peripheral holding NUM_CH independent arithmetic channels.
- Each channel has operand registers A and B, a mode register, and a registered RESULT.
- Modes are add, subtract and accumulate; each channel has a sticky overflow flag in a shared STATUS register.
- Sits on the memory-mapped interconnect as the parametrised, multi-channel successor to the single-channel adder slave.

Parameters:
- DATA_WIDTH, 32, data bus and operand width; must be a multiple of 8.
- ADDR_WIDTH, 8, byte address width; must be at least 8.
- NUM_CH, 4, number of channels; legal range 1..15.

Ports:
- s1_axi_aclk  in  1  clock
- s1_axi_aresetn  in  1  asynchronous active-low reset
- s1_axi_awaddr  in  ADDR_WIDTH  write address
- s1_axi_awvalid  in  1  write address valid
- s1_axi_awready  out  1  write address ready
- s1_axi_wdata  in  DATA_WIDTH  write data
- s1_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s1_axi_wvalid  in  1  write data valid
- s1_axi_wready  out  1  write data ready
- s1_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s1_axi_bvalid  out  1  write response valid
- s1_axi_bready  in  1  write response ready
- s1_axi_araddr  in  ADDR_WIDTH  read address
- s1_axi_arvalid  in  1  read address valid
- s1_axi_arready  out  1  read address ready
- s1_axi_rdata  out  DATA_WIDTH  read data
- s1_axi_rresp  out  2  read response
- s1_axi_rvalid  out  1  read data valid
- s1_axi_rready  in  1  read data ready

Behaviour:
- Register map uses addr[7:4] = channel index c and addr[3:2] = register; addr[1:0] is ignored.
  - Offset 0x0 A, RW.
  - Offset 0x4 B, RW.
  - Offset 0x8 CTRL, RW; bits[1:0] mode: 0 add, 1 sub, 2 acc, 3 reserved (behaves as add); other bits read 0.
  - Offset 0xC RESULT, RO.
  - Address 0xF0 STATUS: bit c = sticky overflow of channel c; write-1-to-clear. Offsets 0xF4..0xFC are invalid.
  - Any c >= NUM_CH with c != 15 is invalid.
- Reset, asynchronous on s1_aresetn low:
  - All A, B, CTRL, RESULT and STATUS registers go to 0.
  - awready, wready, bvalid and rvalid go to 0; bresp, rresp and rdata go to 0.
  - No internal update is left pending; any in-flight transaction is dropped.
- Write channel:
  - awready and wready are driven by one register.
  - They assert for exactly one cycle when awvalid && wvalid && !bvalid && !pend.
  - A single-channel valid (AW only, or W only) is never accepted on its own.
  - On the handshake edge E, the addressed register is updated per wstrb, bvalid rises and bresp is set.
  - bvalid holds until bready is high; the next write is accepted only after that.
- Write response codes:
  - OKAY for A, B, CTRL and STATUS.
  - SLVERR for a write to RESULT or to an invalid address; no state changes.
- Update pipeline:
  - A write to A, B or CTRL of channel c sets pend at E.
  - At E+1, RESULT[c] is recomputed and pend clears:
    - add: A+B
    - sub: A-B
    - acc: only a write to B triggers RESULT <= RESULT+B; in acc mode, writes to A or CTRL leave RESULT unchanged.
  - Arithmetic is DATA_WIDTH wide with wrap-around.
  - Carry-out (add/acc) or borrow (sub) sets STATUS[c] at E+1.
  - If a W1C write to STATUS coincides with a set of the same bit, the set wins.
- Read channel:
  - arready pulses for one cycle when arvalid && !rvalid && !pend.
  - On that edge rdata and rresp are registered and rvalid rises; rvalid holds until rready.
  - Read latency is one cycle from handshake.
  - An invalid address returns rdata 0 with SLVERR.
- Hazards:
  - pend blocks both arready and new writes, so a read never returns a stale RESULT after an accepted write.
  - A read and a write handshaking on the same edge is legal; the read returns the pre-write value.

Decomposition:
- Package axil_adder_pkg holds:
  - register offsets (A, B, CTRL, RESULT), STATUS address, mode codes, response codes (OKAY, SLVERR).
  - the constant for the channel-index field position.
- Sub-module axil_adder_channel (one instance per channel, generate loop) contains:
  - A/B/CTRL registers with byte strobes, the mode mux and adder, the RESULT register, and the overflow pulse output.
- The top level contains the AXI handshake logic, address decode, the STATUS register and the read mux.

Test Plan:
- Set NUM_CH=4. Write ch0 A=39 then B=40 (wstrb=0xF) -> bresp OKAY each; read 0x0C -> rdata 79, rresp OKAY, STATUS 0.
- Ch1: CTRL=1, A=5, B=7 -> read 0x1C gives 0xFFFFFFFE, STATUS=0x2; write STATUS=0x2 -> STATUS reads 0.
- Ch2: CTRL=2, B=0xFFFFFFF0 then B=0x20 -> RESULT 0x10, STATUS bit2 set; write A=9 -> RESULT remains 0x10.
- Write 0x35 (ch3, B) -> OKAY; write 0x45 (ch4) and 0x0C (RESULT) -> SLVERR with no state change; read 0x50 -> rdata 0, SLVERR.
- Hold bready low 5 cycles after a write -> awready/wready stay 0 and the next AW/W waits. Present AW without W -> never accepted.
- Assert reset while bvalid=1 and rvalid=1 -> all outputs and registers return to 0 immediately; the first post-reset write completes normally.

Source files
------------

// File: rtl/axil_adder_pkg.sv
// Shared constants for the multi-channel AXI4-Lite adder slave.
// Register offsets, STATUS address, modes and response codes.
package axil_adder_pkg;

  localparam logic [1:0] REG_A      = 2'd0;
  localparam logic [1:0] REG_B      = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam logic [7:0] STATUS_ADDR = 8'hF0;
  localparam int         CH_LSB      = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

endpackage

// File: rtl/axil_adder_channel.sv
// One arithmetic channel: A/B/CTRL registers, mode mux,
// registered RESULT and a one-cycle overflow pulse.
module axil_adder_channel
  import axil_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [1:0]              wr_sel,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   a_q,
  output logic [DATA_WIDTH-1:0]   b_q,
  output logic [DATA_WIDTH-1:0]   result_q,
  output mode_e                   mode_q,
  output logic                    ovf
);

  localparam int NB = DATA_WIDTH / 8;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] q,
    input logic [DATA_WIDTH-1:0] d,
    input logic [NB-1:0]         s
  );
    merge = q;
    for (int i = 0; i < NB; i++)
      if (s[i]) merge[8*i +: 8] = d[8*i +: 8];
  endfunction

  logic                  upd;
  logic                  upd_b;
  logic                  go;
  logic [DATA_WIDTH:0]   sum;

  // Top bit of the widened sum is carry for add/acc, borrow for sub.
  always_comb begin
    sum = '0;
    case (mode_q)
      MODE_SUB: sum = {1'b0, a_q} - {1'b0, b_q};
      MODE_ACC: sum = {1'b0, result_q} + {1'b0, b_q};
      default:  sum = {1'b0, a_q} + {1'b0, b_q};
    endcase
  end

  assign go  = upd && (mode_q != MODE_ACC || upd_b);
  assign ovf = go && sum[DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_ADD;
      result_q <= '0;
      upd      <= 1'b0;
      upd_b    <= 1'b0;
    end else begin
      upd   <= wr_en;
      upd_b <= wr_en && (wr_sel == REG_B);
      if (wr_en) begin
        case (wr_sel)
          REG_A:    a_q <= merge(a_q, wdata, wstrb);
          REG_B:    b_q <= merge(b_q, wdata, wstrb);
          REG_CTRL: if (wstrb[0]) mode_q <= mode_e'(wdata[1:0]);
          default:  ;
        endcase
      end
      if (go) result_q <= sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/axil_adder_array.sv
// AXI4-Lite slave with NUM_CH adder channels and a shared
// write-1-to-clear overflow STATUS register.
module axil_adder_array
  import axil_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  logic [3:0]            wch, rch;
  logic [1:0]            wreg, rreg;
  logic                  w_status, r_status;
  logic                  w_ok, r_ok;
  logic                  hs_w, hs_r;
  logic                  wr_rdy, rd_rdy, pend;
  logic [NUM_CH-1:0]     status_q, status_clr, ovf_v;
  logic [DATA_WIDTH-1:0] wmask, rd_mux;
  logic [DATA_WIDTH-1:0] a_v   [NUM_CH];
  logic [DATA_WIDTH-1:0] b_v   [NUM_CH];
  logic [DATA_WIDTH-1:0] res_v [NUM_CH];
  mode_e                 mode_v[NUM_CH];
  logic                  unused_addr;

  assign unused_addr = ^{s1_axi_awaddr, s1_axi_araddr};

  assign wch      = s1_axi_awaddr[CH_LSB +: 4];
  assign wreg     = s1_axi_awaddr[3:2];
  assign w_status = s1_axi_awaddr[7:2] == STATUS_ADDR[7:2];
  assign w_ok     = w_status ||
                    (int'(wch) < NUM_CH && wreg != REG_RESULT);

  assign rch      = s1_axi_araddr[CH_LSB +: 4];
  assign rreg     = s1_axi_araddr[3:2];
  assign r_status = s1_axi_araddr[7:2] == STATUS_ADDR[7:2];
  assign r_ok     = r_status || int'(rch) < NUM_CH;

  assign hs_w = wr_rdy && s1_axi_awvalid && s1_axi_wvalid;
  assign hs_r = rd_rdy && s1_axi_arvalid;

  assign s1_axi_awready = wr_rdy;
  assign s1_axi_wready  = wr_rdy;
  assign s1_axi_arready = rd_rdy;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axil_adder_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .clk      (s1_axi_aclk),
      .rst_n    (s1_axi_aresetn),
      .wr_en    (hs_w && wch == 4'(c) && wreg != REG_RESULT),
      .wr_sel   (wreg),
      .wdata    (s1_axi_wdata),
      .wstrb    (s1_axi_wstrb),
      .a_q      (a_v[c]),
      .b_q      (b_v[c]),
      .result_q (res_v[c]),
      .mode_q   (mode_v[c]),
      .ovf      (ovf_v[c])
    );
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      wmask[i] = s1_axi_wstrb[i/8];
  end

  assign status_clr = (hs_w && w_status) ?
    (s1_axi_wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]) : '0;

  always_comb begin
    rd_mux = '0;
    if (r_status) begin
      rd_mux[NUM_CH-1:0] = status_q;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rch == 4'(c)) begin
          case (rreg)
            REG_A:    rd_mux = a_v[c];
            REG_B:    rd_mux = b_v[c];
            REG_CTRL: rd_mux = {{(DATA_WIDTH-2){1'b0}}, 2'(mode_v[c])};
            default:  rd_mux = res_v[c];
          endcase
        end
      end
    end
  end

  // A write handshake blocks arready for the same edge so a read
  // can never land on the cycle where RESULT is being refreshed.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      wr_rdy        <= 1'b0;
      rd_rdy        <= 1'b0;
      pend          <= 1'b0;
      status_q      <= '0;
      s1_axi_bvalid <= 1'b0;
      s1_axi_bresp  <= RESP_OKAY;
      s1_axi_rvalid <= 1'b0;
      s1_axi_rresp  <= RESP_OKAY;
      s1_axi_rdata  <= '0;
    end else begin
      wr_rdy <= s1_axi_awvalid && s1_axi_wvalid && !s1_axi_bvalid &&
                !pend && !wr_rdy;
      rd_rdy <= s1_axi_arvalid && !s1_axi_rvalid && !pend &&
                !rd_rdy && !hs_w;
      pend   <= hs_w && w_ok && !w_status;

      if (hs_w) begin
        s1_axi_bvalid <= 1'b1;
        s1_axi_bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s1_axi_bready) begin
        s1_axi_bvalid <= 1'b0;
      end

      if (hs_r) begin
        s1_axi_rvalid <= 1'b1;
        s1_axi_rdata  <= rd_mux;
        s1_axi_rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s1_axi_rready) begin
        s1_axi_rvalid <= 1'b0;
      end

      status_q <= (status_q & ~status_clr) | ovf_v;
    end
  end

endmodule
